// File: rtl/gcd_datapath.sv
// ---------------------------------------------------------------------------
// gcd_datapath
//
// Operand/result datapath for a subtract-and-swap GCD engine. The partner
// control unit sequences load, subtract and swap strobes. This block returns
// the K1/K2 decision flags and captures the final GCD into a result register.
// The result leaves through a valid/ready handshake.
//
// Parameters
//   WIDTH      operand and result width (unsigned)
//   CW         width of the saturating operation counters
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous, active-low reset
//   x_in/y_in  external operands, sampled only on a select-load
//   selectxy   strobe: load the external operands
//   swap       strobe: XR <= YR, YR <= XR
//   subract    strobe: XR <= XR - YR
//   loadxr     XR write enable
//   loadyr     YR write enable
//   K1         YR being written this cycle is non-zero
//   K2         XR being written this cycle is >= YR being written
//   result     captured GCD
//   out_valid  result is valid; held until accepted
//   out_ready  consumer accepts result
//   busy       an operand set is loaded but not yet captured
//   sub_count  subtract operations since the last load (saturating)
//   swap_count swap operations since the last load (saturating)
//   err        sticky flag for illegal strobe combinations
// ---------------------------------------------------------------------------
module gcd_datapath #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic             selectxy,
    input  logic             swap,
    input  logic             subract,
    input  logic             loadxr,
    input  logic             loadyr,
    output logic             K1,
    output logic             K2,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    sub_count,
    output logic [CW-1:0]    swap_count,
    output logic             err
);

    logic [WIDTH-1:0] r_xr;
    logic [WIDTH-1:0] r_yr;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_busy;
    logic [CW-1:0]    r_sub_count;
    logic [CW-1:0]    r_swap_count;
    logic             r_err;

    logic [WIDTH-1:0] w_xr_d;
    logic [WIDTH-1:0] w_yr_d;
    logic             w_select_load;
    logic             w_sub_op;
    logic             w_swap_op;
    logic             w_illegal;
    logic             w_done;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] one;
        one = {{(CW-1){1'b0}}, 1'b1};
        return (v == {CW{1'b1}}) ? v : v + one;
    endfunction

    // Next-value muxes; priority is selectxy > swap > subtract.
    always_comb begin
        w_xr_d = r_xr;
        w_yr_d = r_yr;
        if (loadxr) begin
            if (selectxy)
                w_xr_d = x_in;
            else if (swap)
                w_xr_d = r_yr;
            else
                w_xr_d = r_xr - r_yr;
        end
        if (loadyr) begin
            if (selectxy)
                w_yr_d = y_in;
            else
                w_yr_d = r_xr;
        end
    end

    // Flags look at the values being written. The controller then decides on
    // the post-operation operands. If the flags came from the register outputs,
    // the controller would act one step late and XR could underflow.
    assign K1 = (w_yr_d != '0);
    assign K2 = (w_xr_d >= w_yr_d);

    assign w_select_load = selectxy & loadxr;
    assign w_sub_op      = loadxr & subract & ~swap & ~selectxy;
    assign w_swap_op     = loadxr & loadyr & swap & ~selectxy;
    assign w_illegal     = (swap & subract)
                         | (loadyr & ~loadxr)
                         | (selectxy & ~(loadxr & loadyr));
    // With both enables low, the controller is in its terminal state.
    // Because busy is qualified, only the first such cycle captures.
    assign w_done        = ~loadxr & ~loadyr & r_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_xr         <= '0;
            r_yr         <= '0;
            r_result     <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_sub_count  <= '0;
            r_swap_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_xr <= w_xr_d;
            r_yr <= w_yr_d;

            if (w_illegal)
                r_err <= 1'b1;

            if (w_select_load) begin
                r_busy       <= 1'b1;
                r_sub_count  <= '0;
                r_swap_count <= '0;
            end else begin
                if (w_sub_op)
                    r_sub_count <= sat_inc(r_sub_count);
                if (w_swap_op)
                    r_swap_count <= sat_inc(r_swap_count);
            end

            // A capture wins over a handshake. The handshake needs out_valid
            // to be high already, so a ready in the capture cycle is ignored.
            if (w_done) begin
                r_result    <= r_xr;
                r_out_valid <= 1'b1;
                r_busy      <= 1'b0;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign result     = r_result;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign sub_count  = r_sub_count;
    assign swap_count = r_swap_count;
    assign err        = r_err;

endmodule

// File: tb/tb_gcd_datapath.sv
// ---------------------------------------------------------------------------
// tb_gcd_datapath
//
// Directed bench for gcd_datapath. A small behavioural controller (S0 load,
// S1 swap, S2 subtract, S3 done) reacts to the K1/K2 flags. It drives a
// table of operand pairs whose results, counter values and latencies were
// worked out by hand. Hand-written sequences cover the other cases:
// backpressure, same-cycle ready, reset mid-run and illegal strobes.
// ---------------------------------------------------------------------------
module tb_gcd_datapath;

    localparam int WIDTH = 8;
    localparam int CW    = 8;

    localparam int S0 = 0;
    localparam int S1 = 1;
    localparam int S2 = 2;
    localparam int S3 = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             selectxy;
    logic             swap;
    logic             subract;
    logic             loadxr;
    logic             loadyr;
    logic             K1;
    logic             K2;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CW-1:0]    sub_count;
    logic [CW-1:0]    swap_count;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] res;
        int               subs;
        int               swaps;
        int               lat;
        logic             k1_load;
    } vec_t;

    vec_t vecs[7];

    gcd_datapath #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x_in       (x_in),
        .y_in       (y_in),
        .selectxy   (selectxy),
        .swap       (swap),
        .subract    (subract),
        .loadxr     (loadxr),
        .loadyr     (loadyr),
        .K1         (K1),
        .K2         (K2),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .sub_count  (sub_count),
        .swap_count (swap_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_strobes(input int st);
        selectxy = 1'b0;
        swap     = 1'b0;
        subract  = 1'b0;
        loadxr   = 1'b0;
        loadyr   = 1'b0;
        case (st)
            S0: begin selectxy = 1'b1; loadxr = 1'b1; loadyr = 1'b1; end
            S1: begin swap = 1'b1; loadxr = 1'b1; loadyr = 1'b1; end
            S2: begin subract = 1'b1; loadxr = 1'b1; end
            default: ;
        endcase
    endtask

    // Runs one computation under the behavioural controller.
    // lat is the cycle (after the load cycle) in which out_valid is first seen.
    task automatic run_vec(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           output int lat, output logic k1_load, output logic timeout);
        int st;
        int nxt;
        int cyc;
        @(negedge clk);
        x_in = x;
        y_in = y;
        st   = S0;
        set_strobes(st);
        cyc     = 0;
        lat     = -1;
        timeout = 1'b0;
        k1_load = 1'bx;
        forever begin
            #1;
            if (cyc == 0)
                k1_load = K1;
            if (st == S1)
                nxt = S2;
            else if (st == S3)
                nxt = S3;
            else if (!K1)
                nxt = S3;
            else if (K2)
                nxt = S2;
            else
                nxt = S1;
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                lat = cyc;
                break;
            end
            if (cyc > 400) begin
                timeout = 1'b1;
                break;
            end
            st = nxt;
            set_strobes(st);
        end
        set_strobes(S3);
    endtask

    initial begin
        int   lat;
        logic k1l;
        logic to;
        logic ok;

        vecs[0] = '{8'd12,  8'd8,  8'd4,  4,   2, 8,   1'b1};
        vecs[1] = '{8'd9,   8'd0,  8'd9,  0,   0, 2,   1'b0};
        vecs[2] = '{8'd0,   8'd5,  8'd5,  1,   1, 4,   1'b1};
        vecs[3] = '{8'd0,   8'd0,  8'd0,  0,   0, 2,   1'b0};
        vecs[4] = '{8'd7,   8'd7,  8'd7,  2,   1, 5,   1'b1};
        vecs[5] = '{8'd15,  8'd6,  8'd3,  5,   2, 9,   1'b1};
        // 256 subtracts are needed; sub_count saturates at 255
        vecs[6] = '{8'd255, 8'd1,  8'd1,  255, 1, 259, 1'b1};

        reset_n   = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        set_strobes(S3);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst result", result, 0);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst sub_count", sub_count, 0);
        check("rst swap_count", swap_count, 0);
        check("rst K1", K1, 0);
        check("rst K2", K2, 1);
        reset_n = 1'b1;

        // Table of operand pairs
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i].x, vecs[i].y, lat, k1l, to);
            check($sformatf("v%0d timeout", i), to, 0);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d K1 load", i), k1l, vecs[i].k1_load);
            check($sformatf("v%0d result", i), result, vecs[i].res);
            check($sformatf("v%0d sub_count", i), sub_count, vecs[i].subs);
            check($sformatf("v%0d swap_count", i), swap_count, vecs[i].swaps);
            check($sformatf("v%0d busy", i), busy, 0);
            check($sformatf("v%0d err", i), err, 0);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check($sformatf("v%0d valid after ready", i), out_valid, 0);
            check($sformatf("v%0d result held", i), result, vecs[i].res);
        end

        // Backpressure: result held for 10 cycles without ready
        run_vec(8'd255, 8'd85, lat, k1l, to);
        check("bp latency", lat, 7);
        check("bp result", result, 85);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || result != 8'd85)
                ok = 1'b0;
        end
        check("bp hold", ok, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp valid cleared", out_valid, 0);
        check("bp result kept", result, 85);

        // Ready already high in the capture cycle: valid must last one cycle
        out_ready = 1'b1;
        run_vec(8'd12, 8'd8, lat, k1l, to);
        check("rdy-early latency", lat, 8);
        check("rdy-early result", result, 4);
        @(negedge clk);
        check("rdy-early valid one cycle", out_valid, 0);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid)
                ok = 1'b0;
        end
        check("no recapture", ok, 1);
        out_ready = 1'b0;

        // Reset during the 2nd subtract of 12, 8
        @(negedge clk);
        x_in = 8'd12;
        y_in = 8'd8;
        set_strobes(S0);
        @(negedge clk);
        set_strobes(S2);
        @(negedge clk);
        set_strobes(S1);
        @(negedge clk);
        set_strobes(S2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_strobes(S3);
        #1;
        check("midrst result", result, 0);
        check("midrst out_valid", out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst sub_count", sub_count, 0);
        check("midrst swap_count", swap_count, 0);
        check("midrst err", err, 0);
        check("midrst K1", K1, 0);
        check("midrst K2", K2, 1);
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy)
                ok = 1'b0;
        end
        check("midrst no valid", ok, 1);

        // Illegal swap & subtract is sticky through a legal run
        @(negedge clk);
        loadxr  = 1'b1;
        swap    = 1'b1;
        subract = 1'b1;
        @(negedge clk);
        set_strobes(S3);
        check("illegal swap+sub err", err, 1);
        run_vec(8'd12, 8'd8, lat, k1l, to);
        check("err sticky", err, 1);
        check("post-err result", result, 4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("err cleared by reset", err, 0);

        // Illegal loadyr without loadxr
        loadyr = 1'b1;
        @(negedge clk);
        set_strobes(S3);
        check("illegal loadyr err", err, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("err cleared again", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_datapath.md
# gcd_datapath

Datapath stage paired with the subtract/swap GCD control unit. It holds the X and Y operand registers and carries out the load, swap and subtract operations selected by the controller's strobes. It returns the K1/K2 status flags that drive the controller's next-state decision, and it captures the final GCD into a result register with a valid/ready output handshake. It also keeps saturating operation counters and a sticky error flag for illegal strobe combinations.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width (unsigned).
- `CW`, default 8: width of the operation counters.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset is synchronous and active-low. The controller's active-high `reset` is driven from `~reset_n` at integration.
- `x_in`, in, WIDTH: operand X, sampled only on a select-load.
- `y_in`, in, WIDTH: operand Y, sampled only on a select-load.
- `selectxy`, in, 1: controller strobe; choose the external operands.
- `swap`, in, 1: controller strobe; exchange XR and YR.
- `subract`, in, 1: controller strobe; XR <= XR − YR.
- `loadxr`, in, 1: XR write enable.
- `loadyr`, in, 1: YR write enable.
- `K1`, out, 1: post-operation YR != 0.
- `K2`, out, 1: post-operation XR >= YR.
- `result`, out, WIDTH: captured GCD.
- `out_valid`, out, 1: `result` is valid.
- `out_ready`, in, 1: consumer accepts `result`.
- `busy`, out, 1: an operand set is loaded and not yet captured.
- `sub_count`, out, CW: subtract operations performed, saturating.
- `swap_count`, out, CW: swap operations performed, saturating.
- `err`, out, 1: sticky illegal-strobe flag.

## Operation
- **Next-value computation (combinational).**
  - XR_d = loadxr ? (selectxy ? x_in : swap ? YR : XR − YR) : XR.
  - YR_d = loadyr ? (selectxy ? y_in : XR) : YR.
  - Mux priority: selectxy > swap > subtract.
  - Subtraction is WIDTH-bit modulo. Underflow cannot occur under a legal controller sequence.
- **Flags.** K1 = (YR_d != 0) and K2 = (XR_d >= YR_d). Flags are computed from the D-inputs, not the Q-outputs, so the controller decides on the values being written this cycle. This is mandatory: flags computed from Q lead to a stale decision in S2 and to underflow.
- **Flag path.** The flag path is purely combinational. There is no loop, because the controller strobes depend only on its state register.
- **Register update.** XR <= XR_d and YR <= YR_d every cycle.
- **Done detection.** loadxr = 0 and loadyr = 0 is the controller's terminal state. On the first such cycle with `busy` = 1:
  - result <= XR;
  - out_valid <= 1;
  - busy <= 0.
- **Starting a computation.** busy <= 1 on any cycle with selectxy & loadxr.
- **Output handshake.**
  - out_valid holds until out_valid & out_ready, then clears.
  - `result` holds its value after the handshake.
  - No new capture happens until the next select-load.
- **Counters.**
  - sub_count increments on loadxr & subract & ~swap & ~selectxy.
  - swap_count increments on loadxr & loadyr & swap & ~selectxy.
  - Both saturate at 2^CW − 1.
  - Both clear on a select-load.
- **Error flag.** err <= 1 when any of these holds; it stays set until reset:
  - swap & subract;
  - loadyr & ~loadxr;
  - selectxy & ~(loadxr & loadyr).
- **Boundary results.**
  - y_in = 0: K1 = 0 in the load cycle, and result = x_in.
  - x_in = 0, y_in ≠ 0: one swap followed by a subtract of 0, and result = y_in.
  - Both operands 0: result = 0.

## Timing
- **Reset** (reset_n = 0 at a rising edge) sets:
  - XR = 0, YR = 0, result = 0;
  - out_valid = 0, busy = 0, err = 0;
  - sub_count = 0, swap_count = 0.
- **Flags during reset.** With XR = YR = 0, K1 = 0 and K2 = 1 (when no load is asserted).
- **Reset mid-computation.** A reset during a computation aborts it; no result is produced.
- **Latency.** Each controller state costs one cycle. out_valid rises one cycle after the controller enters the terminal state. For the 12,8 example below, that is 8 cycles after the load cycle.
- **Simultaneous events.** If out_ready arrives in the same cycle out_valid is set, it has no effect; a handshake needs out_valid already high.

## Test plan
- **12, 8.** Strobe sequence S0,S2,S1,S2,S2,S1,S2,S3 -> result = 4, sub_count = 4, swap_count = 2, out_valid high until out_ready, err = 0.
- **x = 9, y = 0.** K1 = 0 in the load cycle -> result = 9, both counters 0.
- **x = 0, y = 5.** -> result = 5, swap_count = 1, sub_count = 1. XR never underflows.
- **Output backpressure.** 255, 85 with out_ready held 0 for 10 cycles -> out_valid stays 1, result stays 85. A single out_ready pulse clears out_valid the next cycle.
- **Reset mid-run.** reset_n low during the 2nd subtract of 12, 8 -> all outputs 0 the next cycle, and no out_valid.
- **Illegal strobes.** Force swap = subract = 1 with loadxr = 1 -> err = 1, and it stays set until reset_n.
